io_config_loader: RTL

Configuration transmitter for the daisy-chained IO configuration shift registers. It accepts one 16-bit configuration word per IO block and buffers all of them. It then drives the serial programming stream (bit_out, prgm_b, io_prgm_b, chain-enable token) into the first IO block of the chain. Finally it waits for the chain-done token from the last block and reports completion or timeout to the configuration controller.

---
 rtl/io_config_loader_if.sv | 10 +
 rtl/io_config_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/io_config_loader_if.sv
// Configuration word handshake between the configuration controller
// (master) and the IO configuration loader (slave).
interface io_config_loader_if;
    logic [15:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/io_config_loader.sv
// IO configuration loader: buffers one 16-bit word per IO block, then streams
// them as 17-bit frames (pad + 16 data bits) into a daisy chain of shift
// registers and waits for the chain-done token from the last block.
module io_config_loader #(
    parameter int NUM_BLOCKS   = 4,
    parameter int DONE_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    io_config_loader_if.slave cfg,
    input  logic              chain_done_in,
    output logic              bit_out,
    output logic              prgm_b,
    output logic              io_prgm_b,
    output logic              chain_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
    localparam int BUF_DEPTH = 1 << IW;
    localparam logic [IW-1:0] LAST_BLK  = IW'(NUM_BLOCKS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAIT_DONE, FINISH} state_t;

    state_t        state;
    logic [15:0]   cfg_buf [BUF_DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] frame_idx;
    logic [4:0]    bit_idx;
    logic [TW-1:0] timer;

    // Bit idx of a frame: 0 is the pad, 1..16 send each G/S pair low bit
    // first, starting from the top pair (14,15,12,13,...,0,1).
    function automatic logic frame_bit(input logic [15:0] word, input logic [4:0] idx);
        logic [3:0] pos;
        logic [3:0] sel;
        pos = 4'(idx - 5'd1);
        sel = {~pos[3:1], pos[0]};
        return (idx == 5'd0) ? 1'b0 : word[sel];
    endfunction

    // Load/shift/wait sequencer; every output is a register of this block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cfg.cfg_ready <= 1'b0;
            bit_out       <= 1'b0;
            prgm_b        <= 1'b1;
            io_prgm_b     <= 1'b0;
            chain_en      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            wr_idx        <= '0;
            frame_idx     <= '0;
            bit_idx       <= '0;
            timer         <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                cfg_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // chain_en drops here so the receivers see a fresh
                        // enable edge when shifting begins.
                        state         <= LOAD;
                        cfg.cfg_ready <= 1'b1;
                        chain_en      <= 1'b0;
                        busy          <= 1'b1;
                        wr_idx        <= '0;
                    end
                end
                LOAD: begin
                    if (cfg.cfg_valid && cfg.cfg_ready) begin
                        cfg_buf[wr_idx] <= cfg.cfg_data;
                        if (wr_idx == LAST_BLK) begin
                            // Enter SHIFT with the pad bit already on bit_out
                            // so there is no bubble after the last accept.
                            state         <= SHIFT;
                            cfg.cfg_ready <= 1'b0;
                            prgm_b        <= 1'b0;
                            io_prgm_b     <= 1'b1;
                            chain_en      <= 1'b1;
                            bit_out       <= 1'b0;
                            bit_idx       <= '0;
                            frame_idx     <= '0;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (bit_idx == 5'd16) begin
                        bit_idx <= '0;
                        bit_out <= 1'b0;
                        if (frame_idx == LAST_BLK) begin
                            state <= WAIT_DONE;
                            timer <= '0;
                        end else begin
                            frame_idx <= frame_idx + IW'(1);
                        end
                    end else begin
                        bit_idx <= bit_idx + 5'd1;
                        bit_out <= frame_bit(cfg_buf[frame_idx], bit_idx + 5'd1);
                    end
                end
                WAIT_DONE: begin
                    if (chain_done_in) begin
                        state     <= FINISH;
                        done      <= 1'b1;
                        prgm_b    <= 1'b1;
                        io_prgm_b <= 1'b0;
                    end else if (timer == LAST_TICK) begin
                        state     <= FINISH;
                        error     <= 1'b1;
                        prgm_b    <= 1'b1;
                        io_prgm_b <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                FINISH: begin
                    // chain_en is left high to keep the receivers frozen.
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
